// File: rtl/keypad_cmd_scan.sv
// keypad_cmd_scan: scans a 4x4 active-low keypad, debounces, emits one cmd strobe per key press
// ports: clock, reset (sync active-low), row_n[3:0] in (async, pulled up),
//        col_n[3:0] one-hot-low drive, cmd[3:0] = {row,col} while cmd_valid, cmd_valid strobe,
//        key_held high from strobe until release is confirmed
module keypad_cmd_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic [7:0]  DEBOUNCE = 8'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_held
);
  typedef enum logic [1:0] {S_SCAN, S_DEB, S_EMIT, S_WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] s1, rs, pat, pat_nx, low;
  logic [15:0] win;
  logic [1:0] col, col_nx;
  logic [7:0] mcnt, mcnt_nx, rcnt, rcnt_nx;
  logic sample, valid;
  function automatic logic [1:0] enc(input logic [3:0] p);
    enc = !p[0] ? 2'd0 : !p[1] ? 2'd1 : !p[2] ? 2'd2 : 2'd3;
  endfunction
  assign sample = win == SCAN_DIV - 16'd1;
  assign low = ~rs;
  // exactly one row low; idle and ghost patterns are both rejected
  assign valid = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign col_n = ~(4'b0001 << col);
  always_comb begin
    state_nx = state;
    col_nx = col;
    pat_nx = pat;
    mcnt_nx = mcnt;
    rcnt_nx = rcnt;
    case (state)
      S_SCAN:
        if (sample) begin
          if (valid) begin
            pat_nx = rs;
            mcnt_nx = 8'd1;
            state_nx = (DEBOUNCE <= 8'd1) ? S_EMIT : S_DEB;
          end else col_nx = col + 2'd1;
        end
      S_DEB:
        if (sample) begin
          if (rs == pat) begin
            mcnt_nx = mcnt + 8'd1;
            if (mcnt_nx >= DEBOUNCE) state_nx = S_EMIT;
          end else begin
            state_nx = S_SCAN;
            col_nx = col + 2'd1;
          end
        end
      S_EMIT: begin
        state_nx = S_WAIT;
        rcnt_nx = 8'd0;
      end
      S_WAIT:
        if (sample) begin
          if (rs == 4'hf) begin
            rcnt_nx = rcnt + 8'd1;
            if (rcnt_nx >= DEBOUNCE) begin
              state_nx = S_SCAN;
              col_nx = col + 2'd1;
              rcnt_nx = 8'd0;
            end
          end else rcnt_nx = 8'd0;
        end
      default: state_nx = S_SCAN;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 4'hf;
      rs <= 4'hf;
      win <= 16'd0;
      state <= S_SCAN;
      col <= 2'd0;
      pat <= 4'hf;
      mcnt <= 8'd0;
      rcnt <= 8'd0;
      cmd <= 4'h0;
      cmd_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      s1 <= row_n;
      rs <= s1;
      win <= sample ? 16'd0 : win + 16'd1;
      state <= state_nx;
      col <= col_nx;
      pat <= pat_nx;
      mcnt <= mcnt_nx;
      rcnt <= rcnt_nx;
      cmd <= (state_nx == S_EMIT) ? {enc(pat_nx), col_nx} : 4'h0;
      cmd_valid <= state_nx == S_EMIT;
      key_held <= (state_nx == S_EMIT) || (state_nx == S_WAIT);
    end
  end
endmodule

// File: tb/tb_keypad_cmd_scan.sv
// tb_keypad_cmd_scan: directed bench for keypad_cmd_scan with SCAN_DIV=8, DEBOUNCE=3
module tb_keypad_cmd_scan;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row_n, col_n, cmd;
  logic cmd_valid, key_held;
  logic [15:0] keys = 16'h0;
  logic [3:0] c;
  int total = 0, bad = 0, strobes = 0;
  int n, s0;
  bit ok;
  always #5 clock = ~clock;
  keypad_cmd_scan #(.SCAN_DIV(16'd8), .DEBOUNCE(8'd3)) dut (
    .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n),
    .cmd(cmd), .cmd_valid(cmd_valid), .key_held(key_held)
  );
  // key k = 4*row+col pulls its row low while its column is driven
  always_comb begin
    row_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keys[4*r+k] && !col_n[k]) row_n[r] = 1'b0;
  end
  always @(negedge clock) begin
    total++;
    assert ($countones(~col_n) === 1) else begin
      bad++;
      $error("FAIL col_onehot got=%b exp=one low bit", col_n);
    end
    if (!cmd_valid) begin
      total++;
      assert (cmd === 4'h0) else begin
        bad++;
        $error("FAIL cmd_idle got=%h exp=0", cmd);
      end
    end
    if (cmd_valid) strobes++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
    #1;
  endtask
  task automatic wait_col(input logic [3:0] w, output bit f);
    int i;
    f = 1'b0;
    i = 0;
    while (col_n === w && i < 64) begin step(); i++; end
    while (col_n !== w && i < 64) begin step(); i++; end
    f = (col_n === w);
  endtask
  task automatic wait_strobe(input int lim, output int k, output logic [3:0] v);
    k = -1;
    v = 4'h0;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (cmd_valid) begin k = i; v = cmd; break; end
    end
  endtask
  task automatic wait_release(input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (!key_held) begin k = i; break; end
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_col", col_n, 4'b1110);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      chk("idle_col", col_n, ~(4'b0001 << ((i / 8) % 4)) & 4'hf);
      step();
    end
    chk("idle_strobes", strobes, 0);
    wait_col(4'b1110, ok);
    chk("t2_col0", ok, 1);
    keys[9] = 1'b1;
    wait_col(4'b1101, ok);
    chk("t2_col1", ok, 1);
    s0 = strobes;
    wait_strobe(100, n, c);
    chk("t2_latency", n + 1, 25);
    chk("t2_cmd", c, 9);
    chk("t2_held", key_held, 1);
    step();
    chk("t2_one_clk", cmd_valid, 0);
    repeat (40) step();
    chk("t2_held_on", key_held, 1);
    keys = 16'h0;
    wait_release(100, n);
    chk("t2_released", n > 0, 1);
    chk("t2_next_col", col_n, 4'b1011);
    chk("t2_strobes", strobes - s0, 1);
    wait_col(4'b0111, ok);
    chk("t3_col3", ok, 1);
    s0 = strobes;
    keys[7] = 1'b1;
    repeat (8) step();
    chk("t3_col_held", col_n, 4'b0111);
    keys = 16'h0;
    repeat (8) step();
    chk("t3_abort_col", col_n, 4'b1110);
    chk("t3_no_strobe", strobes - s0, 0);
    keys[7] = 1'b1;
    wait_strobe(200, n, c);
    chk("t3_cmd", c, 7);
    chk("t3_strobes", strobes - s0, 1);
    keys = 16'h0;
    wait_release(100, n);
    chk("t3_released", n > 0, 1);
    s0 = strobes;
    keys[2] = 1'b1;
    keys[6] = 1'b1;
    wait_col(4'b1011, ok);
    chk("t4_col2", ok, 1);
    repeat (8) step();
    chk("t4_adv3", col_n, 4'b0111);
    repeat (8) step();
    chk("t4_adv0", col_n, 4'b1110);
    repeat (64) step();
    chk("t4_no_strobe", strobes - s0, 0);
    chk("t4_held", key_held, 0);
    keys = 16'h0;
    s0 = strobes;
    keys[15] = 1'b1;
    wait_strobe(200, n, c);
    chk("t5_cmd", c, 15);
    repeat (400) step();
    keys[3] = 1'b1;
    repeat (400) step();
    keys[3] = 1'b0;
    chk("t5_one_strobe", strobes - s0, 1);
    keys[15] = 1'b0;
    repeat (8) step();
    keys[15] = 1'b1;
    repeat (8) step();
    chk("t5_bounce_held", key_held, 1);
    keys = 16'h0;
    wait_release(100, n);
    chk("t5_released", n > 0, 1);
    chk("t5_strobes", strobes - s0, 1);
    keys[9] = 1'b1;
    wait_col(4'b1101, ok);
    chk("t6_col1", ok, 1);
    repeat (9) step();
    chk("t6_deb_col", col_n, 4'b1101);
    s0 = strobes;
    reset = 1'b0;
    step();
    chk("t6_rst_col", col_n, 4'b1110);
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_held", key_held, 0);
    reset = 1'b1;
    chk("t6_no_strobe", strobes - s0, 0);
    wait_strobe(200, n, c);
    chk("t6_redetect", c, 9);
    chk("t6_strobes", strobes - s0, 1);
    repeat (20) step();
    chk("t6_wait_held", key_held, 1);
    reset = 1'b0;
    step();
    chk("t6_rst2_held", key_held, 0);
    chk("t6_rst2_col", col_n, 4'b1110);
    chk("t6_rst2_valid", cmd_valid, 0);
    reset = 1'b1;
    wait_strobe(200, n, c);
    chk("t6_redetect2", c, 9);
    keys = 16'h0;
    wait_release(100, n);
    chk("t6_released", n > 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
